// File: rtl/mem_stage_pkg.sv
// Shared defines for the memory-access stage: bus widths, stall encoding,
// load-op bit positions and the execute-to-memory bus layout.
package mem_stage_pkg;

   localparam int EX_TO_MEM_WD = 81;
   localparam int MEM_TO_WB_WD = 70;
   localparam int MEM_TO_ID_WD = 38;
   localparam int StallBus     = 6;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   // Bit positions inside the one-hot ram_op field
   localparam int RAM_OP_LB  = 4;
   localparam int RAM_OP_LBU = 3;
   localparam int RAM_OP_LH  = 2;
   localparam int RAM_OP_LHU = 1;
   localparam int RAM_OP_LW  = 0;

   localparam logic [4:0] LD_LB  = 5'b1 << RAM_OP_LB;
   localparam logic [4:0] LD_LBU = 5'b1 << RAM_OP_LBU;
   localparam logic [4:0] LD_LH  = 5'b1 << RAM_OP_LH;
   localparam logic [4:0] LD_LHU = 5'b1 << RAM_OP_LHU;
   localparam logic [4:0] LD_LW  = 5'b1 << RAM_OP_LW;

   typedef struct packed {
      logic [4:0]  ram_op;
      logic [31:0] pc;
      logic        data_ram_en;
      logic [3:0]  data_ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] ex_result;
   } ex_to_mem_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of the stall vector, the execute/SRAM inputs and the two
// outgoing buses of the memory stage.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic [StallBus-1:0]     stall;
   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
   logic [31:0]             data_sram_rdata;
   logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
   logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;

   modport master (
      output stall, ex_to_mem_bus, data_sram_rdata,
      input  mem_to_wb_bus, mem_to_id_bus
   );

   modport slave (
      input  stall, ex_to_mem_bus, data_sram_rdata,
      output mem_to_wb_bus, mem_to_id_bus
   );

endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load aligner: picks the byte/half/word addressed by the
// low address bits and sign- or zero-extends it to 32 bits.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [4:0]  ram_op,
   input  logic [1:0]  offset,
   input  logic [31:0] word,
   output logic [31:0] ext_data
);

   logic [7:0]  byte_val;
   logic [15:0] half_val;

   function automatic logic [31:0] sext8(input logic signed [7:0] v);
      logic signed [31:0] r;
      r = v;
      return r;
   endfunction

   function automatic logic [31:0] sext16(input logic signed [15:0] v);
      logic signed [31:0] r;
      r = v;
      return r;
   endfunction

   always_comb begin
      byte_val = 8'h00;
      case (offset)
         2'd0: byte_val = word[7:0];
         2'd1: byte_val = word[15:8];
         2'd2: byte_val = word[23:16];
         2'd3: byte_val = word[31:24];
         default: byte_val = 8'h00;
      endcase
      half_val = offset[1] ? word[31:16] : word[15:0];

      // Anything other than exactly one op bit (including no load) yields zero
      ext_data = '0;
      case (ram_op)
         LD_LB:   ext_data = sext8(byte_val);
         LD_LBU:  ext_data = {24'h0, byte_val};
         LD_LH:   ext_data = sext16(half_val);
         LD_LHU:  ext_data = {16'h0, half_val};
         LD_LW:   ext_data = word;
         default: ext_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers the execute bus under stall control,
// aligns load data (held stable across stalls) and drives WB/forwarding buses.
module mem_stage
   import mem_stage_pkg::*;
(
   input logic        clk,
   input logic        rst,
   mem_stage_if.slave mif
);

   ex_to_mem_t  bus_r;
   logic        hold_valid;
   logic [31:0] hold_data;
   logic        ex_held;
   logic        mem_held;
   logic        bus_adv;
   logic [31:0] src_word;
   logic [31:0] load_data;
   logic [31:0] rf_wdata;
   logic        unused_bits;

   assign ex_held  = (mif.stall[3] == Stop);
   assign mem_held = (mif.stall[4] == Stop);
   // bus_r takes a new value (instruction or bubble) unless both stages are held
   assign bus_adv  = !(ex_held && mem_held);

   // Execute -> memory pipeline boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_r <= '0;
      end else if (ex_held && !mem_held) begin
         bus_r <= '0;
      end else if (!ex_held) begin
         bus_r <= ex_to_mem_t'(mif.ex_to_mem_bus);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid <= 1'b0;
      end else if (bus_adv) begin
         hold_valid <= 1'b0;
      end else if (mem_held && !hold_valid) begin
         hold_valid <= 1'b1;
      end
   end

   // SRAM word is only valid in the first MEM cycle; keep a copy for stalls
   always_ff @(posedge clk) begin
      if (mem_held && !hold_valid) begin
         hold_data <= mif.data_sram_rdata;
      end
   end

   assign src_word = hold_valid ? hold_data : mif.data_sram_rdata;

   load_align u_load_align (
      .ram_op   (bus_r.ram_op),
      .offset   (bus_r.ex_result[1:0]),
      .word     (src_word),
      .ext_data (load_data)
   );

   assign rf_wdata = bus_r.sel_rf_res ? load_data : bus_r.ex_result;

   assign mif.mem_to_wb_bus = {bus_r.pc, bus_r.rf_we, bus_r.rf_waddr, rf_wdata};
   assign mif.mem_to_id_bus = {bus_r.rf_we, bus_r.rf_waddr, rf_wdata};

   // Store controls ride along for later stages; other stall bits belong elsewhere
   assign unused_bits = ^{bus_r.data_ram_en, bus_r.data_ram_wen,
                          mif.stall[5], mif.stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// stall/bubble/reset sequences and randomized traffic against a reference model.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   mem_stage_if mif ();

   mem_stage dut (
      .clk (clk),
      .rst (rst),
      .mif (mif)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [4:0]  ram_op;
      logic [31:0] ex_result;
      logic        sel;
      logic [4:0]  waddr;
      logic [31:0] rdata;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs[9];

   // Model state: instruction in MEM, cycles it has spent there, first-cycle word
   ex_to_mem_t  m_bus;
   int          m_age;
   logic [31:0] m_first_word;

   task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_load(logic [4:0] op, logic [1:0] a, logic [31:0] w);
      logic [31:0] b, h;
      b = (w >> (8 * a)) & 32'hFF;
      h = a[1] ? (w >> 16) : (w & 32'hFFFF);
      case (op)
         5'b10000: return (b >= 32'd128)   ? (b | 32'hFFFFFF00) : b;
         5'b01000: return b;
         5'b00100: return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
         5'b00010: return h;
         5'b00001: return w;
         default:  return 32'h0;
      endcase
   endfunction

   function automatic logic [80:0] mk_ex(logic [4:0] op, logic [31:0] pc, logic sel,
                                         logic we, logic [4:0] wa, logic [31:0] res);
      ex_to_mem_t e;
      e = '0;
      e.ram_op = op; e.pc = pc; e.sel_rf_res = sel; e.rf_we = we;
      e.rf_waddr = wa; e.ex_result = res;
      e.data_ram_en = |op;
      return e;
   endfunction

   function automatic logic [69:0] model_wb(logic [31:0] rdata_now);
      logic [31:0] w, wd;
      w  = (m_age == 0) ? rdata_now : m_first_word;
      wd = m_bus.sel_rf_res ? ref_load(m_bus.ram_op, m_bus.ex_result[1:0], w) : m_bus.ex_result;
      return {m_bus.pc, m_bus.rf_we, m_bus.rf_waddr, wd};
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_bus = '0; m_age = 0;
      end else if (mif.stall[3] && mif.stall[4]) begin
         if (m_age == 0) m_first_word = mif.data_sram_rdata;
         m_age++;
      end else if (mif.stall[3]) begin
         m_bus = '0; m_age = 0;
      end else begin
         m_bus = ex_to_mem_t'(mif.ex_to_mem_bus); m_age = 0;
      end
   endtask

   initial begin
      logic [69:0] exp_wb;
      logic [4:0]  op;
      int          r;

      vecs[0] = '{"lb_sext",   5'b10000, 32'h1003, 1'b1, 5'd5,  32'h80AABBCC, 32'hFFFFFF80};
      vecs[1] = '{"lb_a0",     5'b10000, 32'h1000, 1'b1, 5'd6,  32'h80AABBCC, 32'hFFFFFFCC};
      vecs[2] = '{"lbu_a1",    5'b01000, 32'h1001, 1'b1, 5'd7,  32'h80AABBCC, 32'h000000BB};
      vecs[3] = '{"lhu_hi",    5'b00010, 32'h2002, 1'b1, 5'd8,  32'h92345678, 32'h00009234};
      vecs[4] = '{"lh_hi",     5'b00100, 32'h2002, 1'b1, 5'd9,  32'h92345678, 32'hFFFF9234};
      vecs[5] = '{"lh_a1_lo",  5'b00100, 32'h2001, 1'b1, 5'd10, 32'h92348678, 32'hFFFF8678};
      vecs[6] = '{"lw_misal",  5'b00001, 32'h3003, 1'b1, 5'd11, 32'hA5A5C3C3, 32'hA5A5C3C3};
      vecs[7] = '{"non_load",  5'b00000, 32'hDEADBEEF, 1'b0, 5'd12, 32'h12345678, 32'hDEADBEEF};
      vecs[8] = '{"multi_hot", 5'b11000, 32'h4000, 1'b1, 5'd13, 32'hFFFFFFFF, 32'h00000000};

      // Reset
      rst = 1'b1;
      mif.stall = '0;
      mif.ex_to_mem_bus = mk_ex(5'b00001, 32'h1234, 1'b1, 1'b1, 5'd3, 32'h55);
      mif.data_sram_rdata = 32'hFFFFFFFF;
      cyc(); cyc();
      check("reset_wb", mif.mem_to_wb_bus, 70'h0);
      check("reset_id", {32'h0, mif.mem_to_id_bus}, 70'h0);
      check("reset_hold_valid", {69'h0, dut.hold_valid}, 70'h0);
      rst = 1'b0;

      // Directed vectors: launch from EX, check in the first MEM cycle
      foreach (vecs[i]) begin
         mif.ex_to_mem_bus = mk_ex(vecs[i].ram_op, 32'h400 + 32'(i), vecs[i].sel, 1'b1,
                                   vecs[i].waddr, vecs[i].ex_result);
         cyc();
         mif.data_sram_rdata = vecs[i].rdata;
         #1;
         check(vecs[i].name, mif.mem_to_wb_bus,
               {32'h400 + 32'(i), 1'b1, vecs[i].waddr, vecs[i].exp_wdata});
         check({vecs[i].name, "_fwd"}, {32'h0, mif.mem_to_id_bus},
               {32'h0, 1'b1, vecs[i].waddr, vecs[i].exp_wdata});
      end

      // Stall hold: lw whose first MEM cycle is stalled, then SRAM word changes
      mif.ex_to_mem_bus = mk_ex(5'b00001, 32'h500, 1'b1, 1'b1, 5'd7, 32'h100);
      cyc();
      mif.stall = 6'b011111;
      mif.data_sram_rdata = 32'h11111111;
      #1;
      check("stall_first", {38'h0, mif.mem_to_wb_bus[31:0]}, {38'h0, 32'h11111111});
      for (int k = 0; k < 3; k++) begin
         cyc();
         if (k == 2) mif.stall = '0;
         mif.data_sram_rdata = 32'h22222222;
         #1;
         check("stall_hold", {38'h0, mif.mem_to_id_bus[31:0]}, {38'h0, 32'h11111111});
         check("stall_hold_valid", {69'h0, dut.hold_valid}, 70'h1);
      end
      mif.ex_to_mem_bus = mk_ex(5'b00000, 32'h504, 1'b0, 1'b1, 5'd2, 32'h77);
      cyc();
      check("release_hold_valid", {69'h0, dut.hold_valid}, 70'h0);
      check("release_next", mif.mem_to_wb_bus, {32'h504, 1'b1, 5'd2, 32'h77});

      // Bubble: execute held, memory free
      mif.ex_to_mem_bus = mk_ex(5'b00000, 32'h600, 1'b0, 1'b1, 5'd9, 32'hCAFE0001);
      mif.stall = 6'b001111;
      cyc();
      check("bubble", mif.mem_to_wb_bus, 70'h0);
      mif.stall = '0;
      cyc();
      check("after_bubble", mif.mem_to_wb_bus, {32'h600, 1'b1, 5'd9, 32'hCAFE0001});

      // Reset during a stalled load
      mif.ex_to_mem_bus = mk_ex(5'b00001, 32'h700, 1'b1, 1'b1, 5'd4, 32'h0);
      cyc();
      mif.stall = 6'b011111;
      mif.data_sram_rdata = 32'h33333333;
      cyc();
      rst = 1'b1;
      cyc();
      check("rst_mid_stall", mif.mem_to_wb_bus, 70'h0);
      check("rst_mid_stall_hv", {69'h0, dut.hold_valid}, 70'h0);
      rst = 1'b0;
      mif.stall = '0;

      // Randomized traffic against the reference model
      m_bus = '0; m_age = 0; m_first_word = '0;
      rst = 1'b1;
      @(posedge clk); model_edge(); #1;
      rst = 1'b0;
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 4) op = 5'b1 << r;
         else if (r <= 7) op = 5'b0;
         else op = 5'($urandom);
         mif.ex_to_mem_bus = mk_ex(op, $urandom, 1'($urandom), 1'($urandom),
                                   5'($urandom), $urandom);
         mif.data_sram_rdata = $urandom;
         case ($urandom_range(0, 5))
            0:       mif.stall = 6'b001111;
            1, 2:    mif.stall = 6'b011111;
            3:       mif.stall = 6'b111111;
            default: mif.stall = 6'b000000;
         endcase
         rst = ($urandom_range(0, 49) == 0);
         #1;
         exp_wb = model_wb(mif.data_sram_rdata);
         check("rand_wb", mif.mem_to_wb_bus, exp_wb);
         check("rand_id", {32'h0, mif.mem_to_id_bus}, {32'h0, exp_wb[37:0]});
         @(posedge clk);
         model_edge();
         #1;
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage, directly downstream of the execute stage and upstream of write-back. It registers the execute-to-memory bus under control of the global stall vector and takes the synchronous data-SRAM read word. It performs byte/halfword extraction with sign or zero extension and selects the write-back value. It drives the memory-to-writeback bus and the forwarding bus back to decode. A hold buffer keeps load data stable while the stage is stalled.

## Interface
- No parameters. Widths come from the shared defines header: `EX_TO_MEM_WD` = 81, `MEM_TO_WB_WD` = 70, `MEM_TO_ID_WD` = 38, `StallBus` = 6; `Stop` = 1, `NoStop` = 0.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  6  global stall vector; this stage uses stall[3] (execute held) and stall[4] (memory held).
- ex_to_mem_bus  in  81  fields: ram_op[80:76], pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0].
- data_sram_rdata  in  32  read word, valid in the first cycle the load occupies this stage.
- mem_to_wb_bus  out  70  {pc[69:38], rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}.
- mem_to_id_bus  out  38  {rf_we[37], rf_waddr[36:32], rf_wdata[31:0]}; forwarding copy.

## Operation
- Pipeline register `bus_r` (81 bits):
  - rst → 0.
  - stall[3]=Stop and stall[4]=NoStop → 0 (bubble).
  - stall[3]=NoStop → load ex_to_mem_bus.
  - Otherwise hold.
- ram_op is one-hot: [4] lb, [3] lbu, [2] lh, [1] lhu, [0] lw. All zero means not a load.
- Byte offset a = ex_result[1:0].
- Load-data extraction:
  - lb/lbu: byte = word[8a+7:8a].
  - lh/lhu: half = a[1] ? word[31:16] : word[15:0]. a[0] is ignored.
  - lw: full word. a is ignored.
  - lb and lh sign-extend; lbu and lhu zero-extend.
  - ram_op = 0 or an illegal multi-hot value → load data 0.
- Hold buffer:
  - Registers: `hold_valid` (1 bit) and `hold_data` (32 bits).
  - First stalled cycle: if stall[4]=Stop and hold_valid=0, capture data_sram_rdata into hold_data and set hold_valid=1.
  - Clear hold_valid whenever bus_r loads a new value or a bubble, and on rst.
  - Source word = hold_valid ? hold_data : data_sram_rdata.
- rf_wdata = sel_rf_res ? load data : ex_result.
- Output fields:
  - pc, rf_we and rf_waddr pass straight from bus_r.
  - mem_to_id_bus carries the same rf_we/rf_waddr/rf_wdata as mem_to_wb_bus.
- data_ram_en and data_ram_wen are carried in the register only. Stores need no action in this stage.
- No exceptions. Misaligned accesses are silently truncated as described above.

## Timing
- Output values are combinational from bus_r, the hold buffer and data_sram_rdata. No extra latency.
- A load launched by execute in cycle N produces rf_wdata in cycle N+1 (with no stall). The value is visible on mem_to_id_bus in that same cycle.
- Reset values:
  - bus_r = 0 and hold_valid = 0.
  - Both output buses are all-zero, because sel_rf_res=0 and ex_result=0.
- Stall of k cycles on a load:
  - rf_wdata equals the word sampled in the first MEM cycle for all k+1 cycles.
  - This holds even if data_sram_rdata changes after that first cycle.
- stall[3] and stall[4] both Stop: bus_r and the hold buffer hold their values. This is not a bubble.
- rst asserted mid-stall clears everything on the next edge, regardless of stall.

## Structure
- Widths, stall constants and ram_op bit positions belong in the shared defines header. Add `RAM_OP_LB`…`RAM_OP_LW` there.
- One sub-module: `load_align`. It is purely combinational: (ram_op, offset[1:0], word) → 32-bit extended data.
- Pipeline register, hold buffer and bus packing stay in mem_stage.

## Test plan
- Reset: rst=1 for 2 cycles → both buses = 0, hold_valid = 0.
- lb sign extension: ram_op=10000, ex_result=0x1003, sel_rf_res=1, rf_we=1, rf_waddr=5, rdata=0x80AABBCC. Next cycle → rf_wdata=0xFFFFFF80, waddr=5.
- lhu and lh: ex_result=0x2002, rdata=0x9234_5678.
  - lhu → 0x00009234.
  - lh → 0xFFFF9234.
- Non-load: sel_rf_res=0, ex_result=0xDEADBEEF, rdata=0x12345678 → rf_wdata=0xDEADBEEF.
- Stall hold: lw loaded with rdata=0x11111111; next cycle stall[4]=stall[3]=Stop for 3 cycles while rdata=0x22222222 → rf_wdata=0x11111111 throughout. hold_valid clears when stall releases.
- Bubble: stall=6'b001111 with a valid instruction on ex_to_mem_bus → next cycle outputs all zero. Then stall=0 → instruction captured one cycle later.
